vscale_dmem_bridge: RTL

Bridges the vscale_pipeline data-memory port to a single-outstanding valid/ready system bus. The pipeline presents the address in its DX stage and the store data one cycle later in WB, so the bridge captures the address phase and issues one combined bus request during the data phase. It stretches the data phase with `dmem_wait` until the bus responds, then returns the read word and error status. The block sits directly downstream of the pipeline's dmem outputs.

---
 rtl/vscale_dmem_bridge.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vscale_dmem_bridge.sv
// Bridges the vscale pipeline dmem port (address in DX, store data in WB) to a single-outstanding valid/ready bus.
// Optional: define VSCALE_DMEM_MISALIGN_CHECK_EN to complete misaligned accesses locally with an error.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MEM_TYPE_WIDTH
`define MEM_TYPE_WIDTH 3
`endif

module vscale_dmem_bridge (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dmem_en,
  input  logic                       dmem_wen,
  input  logic [`MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [`XPR_LEN-1:0]        dmem_addr,
  input  logic [`XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic [`XPR_LEN-1:0]        dmem_rdata,
  output logic                       dmem_wait,
  output logic                       dmem_badmem_e,
  output logic                       bus_req_valid,
  input  logic                       bus_req_ready,
  output logic                       bus_req_wen,
  output logic [`XPR_LEN-1:0]        bus_req_addr,
  output logic [1:0]                 bus_req_size,
  output logic [3:0]                 bus_req_wstrb,
  output logic [`XPR_LEN-1:0]        bus_req_wdata,
  input  logic                       bus_resp_valid,
  input  logic [`XPR_LEN-1:0]        bus_resp_rdata,
  input  logic                       bus_resp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t              state, next_state;
  logic [`XPR_LEN-1:0] addr_q;
  logic                wen_q;
  logic [1:0]          size_q;
  logic [`XPR_LEN-1:0] rdata_q;
  logic                err_q;
  logic                pend_q;
  logic                resp_done;
  logic                capture;
  logic                misaligned;
  logic                unused_bits;

  function automatic logic [3:0] wstrb_f(input logic wen, input logic [1:0] size,
                                         input logic [1:0] lo);
    logic [3:0] s;
    s = 4'b0000;
    if (wen) begin
      case (size)
        2'd0:    s = 4'b0001 << lo;
        2'd1:    s = 4'b0011 << {lo[1], 1'b0};
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

`ifdef VSCALE_DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((dmem_size[1:0] == 2'd1) && dmem_addr[0]) ||
                      ((dmem_size[1:0] == 2'd2) && (dmem_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // A locally failed access completes without waiting for the bus
  assign resp_done   = pend_q | bus_resp_valid;
  assign capture     = dmem_en && ((state == IDLE) || ((state == RESP) && resp_done));
  assign unused_bits = ^{dmem_size, err_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        addr_q <= dmem_addr;
        wen_q  <= dmem_wen;
        size_q <= dmem_size[1:0];
        pend_q <= misaligned;
      end else if ((state == RESP) && resp_done) begin
        pend_q <= 1'b0;
      end
      if ((state == RESP) && pend_q) begin
        err_q <= 1'b1;
      end else if ((state == RESP) && bus_resp_valid) begin
        rdata_q <= bus_resp_rdata;
        err_q   <= bus_resp_err;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (dmem_en) next_state = misaligned ? RESP : REQ;
      REQ:  if (bus_req_ready) next_state = RESP;
      RESP: if (resp_done) next_state = dmem_en ? (misaligned ? RESP : REQ) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dmem_wait     = 1'b0;
    dmem_rdata    = rdata_q;
    dmem_badmem_e = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_wen   = 1'b0;
    bus_req_addr  = '0;
    bus_req_size  = 2'd0;
    bus_req_wstrb = 4'b0000;
    bus_req_wdata = '0;
    case (state)
      REQ: begin
        dmem_wait     = 1'b1;
        bus_req_valid = 1'b1;
        bus_req_wen   = wen_q;
        bus_req_addr  = {addr_q[`XPR_LEN-1:2], 2'b00};
        bus_req_size  = size_q;
        bus_req_wstrb = wstrb_f(wen_q, size_q, addr_q[1:0]);
        bus_req_wdata = dmem_wdata_delayed;
      end
      RESP: begin
        dmem_wait = !resp_done;
        if (resp_done) dmem_badmem_e = pend_q | bus_resp_err;
        if (bus_resp_valid && !pend_q) dmem_rdata = bus_resp_rdata;
      end
      default: ;
    endcase
  end

endmodule
